// File: rtl/smc_sort_sum.sv
// -----------------------------------------------------------------------------
// smc_sort_sum
//
// Downstream consumer of the six-transistor Id/gm calculator stage. Captures one
// bank of six values (Id or gm, chosen by mode[0]), sorts them in descending
// order with an odd-even transposition network (one pass per cycle), then
// forms a weighted sum of the three largest or three smallest values
// (chosen by mode[1]).
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - upstream offers a set of six Id, six gm values and mode
//   in_ready   - high only in IDLE; a set is taken on in_valid && in_ready
//   mode[0]    - 1: Id bank, weights 3/4/5; 0: gm bank, weights 1/1/1
//   mode[1]    - 1: three largest values; 0: three smallest values
//   id0..id5   - Id values (DATA_W each)
//   gm0..gm5   - gm values (DATA_W each)
//   out_valid  - out_n holds a result, held until out_ready
//   out_ready  - downstream takes the result
//   out_n      - weighted sum (OUT_W, must be >= DATA_W+4)
// -----------------------------------------------------------------------------
module smc_sort_sum #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] id0,
  input  logic [DATA_W-1:0] id1,
  input  logic [DATA_W-1:0] id2,
  input  logic [DATA_W-1:0] id3,
  input  logic [DATA_W-1:0] id4,
  input  logic [DATA_W-1:0] id5,
  input  logic [DATA_W-1:0] gm0,
  input  logic [DATA_W-1:0] gm1,
  input  logic [DATA_W-1:0] gm2,
  input  logic [DATA_W-1:0] gm3,
  input  logic [DATA_W-1:0] gm4,
  input  logic [DATA_W-1:0] gm5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    SUM  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] LAST_PASS = 3'd5;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sort_q [6];
  logic [DATA_W-1:0]  sort_d [6];
  logic [2:0]         cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [OUT_W-1:0]   out_n_q, out_n_d;
  logic               out_valid_q, out_valid_d;

  logic [DATA_W-1:0]  in_id [6];
  logic [DATA_W-1:0]  in_gm [6];
  logic [OUT_W-1:0]   s0, s1, s2;
  logic [OUT_W-1:0]   sum_val;

  assign in_id = '{id0, id1, id2, id3, id4, id5};
  assign in_gm = '{gm0, gm1, gm2, gm3, gm4, gm5};

  // After six passes the registers are descending, so r[0..2] are the three
  // largest and r[3..5] the three smallest; s0 is always the largest of the
  // selected triple.
  always_comb begin
    s0 = OUT_W'(mode_q[1] ? sort_q[0] : sort_q[3]);
    s1 = OUT_W'(mode_q[1] ? sort_q[1] : sort_q[4]);
    s2 = OUT_W'(mode_q[1] ? sort_q[2] : sort_q[5]);
    if (mode_q[0]) begin
      sum_val = OUT_W'(3) * s0 + OUT_W'(4) * s1 + OUT_W'(5) * s2;
    end else begin
      sum_val = s0 + s1 + s2;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sort_d      = sort_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_n_d     = out_n_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sort_d  = mode[0] ? in_id : in_gm;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = SORT;
        end
      end

      SORT: begin
        // Descending order: swap only on strict left < right so ties stay put.
        if (!cnt_q[0]) begin
          for (int i = 0; i < 6; i += 2) begin
            if (sort_q[i] < sort_q[i+1]) begin
              sort_d[i]   = sort_q[i+1];
              sort_d[i+1] = sort_q[i];
            end
          end
        end else begin
          for (int i = 1; i < 5; i += 2) begin
            if (sort_q[i] < sort_q[i+1]) begin
              sort_d[i]   = sort_q[i+1];
              sort_d[i+1] = sort_q[i];
            end
          end
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_PASS) begin
          state_d = SUM;
        end
      end

      SUM: begin
        out_n_d     = sum_val;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        // out_n is left untouched on handoff; only out_valid drops.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_n_q     <= '0;
      out_valid_q <= 1'b0;
      // NOTE: the six sort registers are plain flops, not a RAM, so clearing
      // them on reset is cheap and keeps post-reset state fully defined.
      for (int i = 0; i < 6; i++) begin
        sort_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sort_q      <= sort_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_n_q     <= out_n_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

endmodule

// File: tb/tb_smc_sort_sum.sv
// -----------------------------------------------------------------------------
// tb_smc_sort_sum
//
// Directed bench for smc_sort_sum. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled there too, away from the active edge.
// Expected sums are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_smc_sort_sum;

  localparam int DATA_W = 10;
  localparam int OUT_W  = 14;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [DATA_W-1:0] id [6];
  logic [DATA_W-1:0] gm [6];
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_n;

  int checks   = 0;
  int failures = 0;

  smc_sort_sum #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .id0       (id[0]),
    .id1       (id[1]),
    .id2       (id[2]),
    .id3       (id[3]),
    .id4       (id[4]),
    .id5       (id[5]),
    .gm0       (gm[0]),
    .gm1       (gm[1]),
    .gm2       (gm[2]),
    .gm3       (gm[3]),
    .gm4       (gm[4]),
    .gm5       (gm[5]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [1:0] m,
                            input int i0, input int i1, input int i2,
                            input int i3, input int i4, input int i5,
                            input int g0, input int g1, input int g2,
                            input int g3, input int g4, input int g5);
    mode  = m;
    id[0] = DATA_W'(i0); id[1] = DATA_W'(i1); id[2] = DATA_W'(i2);
    id[3] = DATA_W'(i3); id[4] = DATA_W'(i4); id[5] = DATA_W'(i5);
    gm[0] = DATA_W'(g0); gm[1] = DATA_W'(g1); gm[2] = DATA_W'(g2);
    gm[3] = DATA_W'(g3); gm[4] = DATA_W'(g4); gm[5] = DATA_W'(g5);
  endtask

  // Offer the current inputs at edge E0, then check out_valid stays low through
  // E6 and the result appears right after E7.
  task automatic run_set(input string tag, input int exp_n);
    check({tag, "_in_ready_idle"}, int'(in_ready), 1);
    in_valid = 1'b1;
    step();                       // E0
    in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, int'(in_ready), 0);
    repeat (6) step();            // E1..E6
    check({tag, "_valid_early"}, int'(out_valid), 0);
    step();                       // E7
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_out_n"}, int'(out_n), exp_n);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_in_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_inputs(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_valid", int'(out_valid), 0);
    check("rst_out_n", int'(out_n), 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", int'(in_ready), 1);

    // Id, largest three: sorted 1023,300,100 -> 3*1023+4*300+5*100
    set_inputs(2'b11, 100, 50, 300, 7, 0, 1023, 11, 22, 33, 44, 55, 66);
    run_set("id_large", 4769);
    consume("id_large");

    // Id, smallest three: 50,7,0 -> 150+28+0; gm bank must be ignored
    set_inputs(2'b01, 100, 50, 300, 7, 0, 1023, 900, 800, 700, 600, 500, 400);
    run_set("id_small", 178);
    consume("id_small");

    // gm, smallest three: 6,5,4; id bank must be ignored
    set_inputs(2'b00, 1000, 999, 998, 997, 996, 995, 9, 8, 7, 6, 5, 4);
    run_set("gm_small", 15);
    consume("gm_small");

    // Reset in the middle of SORT discards the operation.
    set_inputs(2'b11, 1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #2;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_out_n", int'(out_n), 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    step();

    // Post-reset set; also gm ties with out_ready held high the whole time.
    set_inputs(2'b10, 3, 3, 3, 3, 3, 3, 5, 5, 5, 5, 5, 5);
    out_ready = 1'b1;
    run_set("gm_ties", 15);
    step();                       // E8: handoff
    check("gm_ties_valid_drop", int'(out_valid), 0);
    check("gm_ties_in_ready", int'(in_ready), 1);
    out_ready = 1'b0;

    // Worst case: 12*1023 without truncation.
    set_inputs(2'b11, 1023, 1023, 1023, 1023, 1023, 1023, 0, 0, 0, 0, 0, 0);
    run_set("worst", 12276);

    // Backpressure: result held, new in_valid ignored for 5 cycles.
    set_inputs(2'b11, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_out_n_%0d", k), int'(out_n), 12276);
      check($sformatf("bp_valid_%0d", k), int'(out_valid), 1);
      check($sformatf("bp_in_ready_%0d", k), int'(in_ready), 0);
    end
    in_valid = 1'b0;
    consume("bp");
    check("bp_out_n_kept", int'(out_n), 12276);

    // Back-to-back sets after release.
    set_inputs(2'b11, 100, 50, 300, 7, 0, 1023, 0, 0, 0, 0, 0, 0);
    run_set("b2b_a", 4769);
    consume("b2b_a");
    set_inputs(2'b00, 0, 0, 0, 0, 0, 0, 9, 8, 7, 6, 5, 4);
    run_set("b2b_b", 15);
    consume("b2b_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/smc_sort_sum.md
Name: smc_sort_sum

Overview:
- Downstream consumer of the six-transistor Id/gm calculator stage.
- Captures either the six Id values or the six gm values, selected by mode.
- Sorts the six captured values iteratively over multiple cycles.
- Outputs a weighted sum of either the three largest or the three smallest values, using a valid/ready handshake on both sides.

Parameters:
- DATA_W, 10, width of each Id/gm input value.
- OUT_W, 14, width of out_n. Must be at least DATA_W+4 so the worst case 12*(2^DATA_W-1) fits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream has a valid set of six Id and six gm values plus mode.
- in_ready  output  1  block can accept a new set; high only in IDLE.
- mode  input  2  mode[0]: 1 selects Id, 0 selects gm. mode[1]: 1 selects the largest three, 0 the smallest three.
- id0..id5  input  DATA_W each  Id values from the calculator stage.
- gm0..gm5  input  DATA_W each  gm values from the calculator stage.
- out_valid  output  1  out_n holds a result.
- out_ready  input  1  downstream accepts the result.
- out_n  output  OUT_W  weighted sum result.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; sort registers and counter clear to 0.
  - Outputs: out_valid=0, out_n=0, in_ready=1 once rst_n deasserts.
  - Reset mid-operation aborts the operation immediately; the partial result is discarded.
- States: IDLE, SORT, SUM, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, load six sort registers from id0..id5 (mode[0]=1) or gm0..gm5 (mode[0]=0), latch mode, clear pass counter, go to SORT.
  - The unselected bank is ignored.
- SORT:
  - Odd-even transposition sort, descending, one pass per cycle, six passes (counter 0..5).
  - Even passes compare-swap pairs (0,1), (2,3), (4,5); odd passes compare-swap (1,2), (3,4).
  - Swap only when left < right, so equal values never swap.
  - After the pass with counter=5, go to SUM.
- SUM (one cycle):
  - Select s0>=s1>=s2 as r[0],r[1],r[2] (largest, mode[1]=1) or r[3],r[4],r[5] (smallest, mode[1]=0).
  - Id mode: out_n = 3*s0 + 4*s1 + 5*s2. gm mode: out_n = s0 + s1 + s2.
  - All arithmetic is unsigned at OUT_W width; no overflow is possible.
  - Register out_n, set out_valid=1, go to DONE.
- DONE:
  - Hold out_n and out_valid stable until an edge with out_ready=1.
  - On that edge: out_valid=0, go to IDLE. out_n keeps its last value.
- Latency: acceptance edge E0; E1..E6 perform the sort passes; E7 registers the result. out_valid is high from after E7 and stays high at least one cycle.
- Throughput: one set per 9 cycles minimum, with out_ready tied high.
- in_ready=0 in SORT, SUM and DONE; in_valid is ignored there, so no input is captured mid-operation.
- mode and inputs need only be stable at the acceptance edge.
- out_ready is ignored while out_valid=0.

Test Plan:
- Reset: assert rst_n=0 mid-SORT -> out_valid=0, out_n=0 and in_ready=1 right after release; the next set is processed correctly.
- Id, largest three: mode=2'b11, id={100,50,300,7,0,1023} -> out_n=4769 at E7, out_valid high.
- Id, smallest three: mode=2'b01, same ids, gm values arbitrary -> out_n=178 (3*50 + 4*7 + 5*0).
- gm, smallest three: mode=2'b00, gm={9,8,7,6,5,4}, ids arbitrary -> out_n=15.
- gm ties: mode=2'b10, all gm=5 -> out_n=15.
- Worst case: mode=2'b11, all id=1023 -> out_n=12276, no truncation.
- Backpressure: hold out_ready=0 for 5 cycles and pulse in_valid -> out_n stable, in_ready=0, no new capture. Release out_ready -> IDLE next cycle, the next set is accepted, and back-to-back results are correct.
